codec_init_seq: RTL
===================

# codec_init_seq

Power-up configuration sequencer for the WM8731 audio codec. It walks a fixed 8-entry register table and drives each entry into the existing `i2c_write` master through its `write`/`done` level handshake, one transfer per entry. It sits directly upstream of `i2c_write` and replaces the ad-hoc phase logic in the board top level. `audio_codec` can therefore rely on a configured DAC once `init_done` is high.

## Interface
Parameters:
- `DEV_ADDR`, default 8'h34: 8-bit I2C write address driven on `i2c_addr` (WM8731 7-bit address 0x1A, R/W=0).
- `STARTUP_CYCLES`, default 50_000: delay after reset release before the first transfer (1 ms at 50 MHz).
- `GAP_CYCLES`, default 500: idle cycles between transfers.
- `TIMEOUT_CYCLES`, default 250_000: maximum wait for `i2c_done` per transfer.
- All three cycle parameters are 1 .. 2^20-1.

Ports:
- `sys_clk`, in, 1: system clock (50 MHz).
- `rst`, in, 1: reset; one clock; reset is asynchronous and active-low.
- `start`, in, 1: re-run request, may be asynchronous (key); synchronised internally.
- `i2c_addr`, out, 8: constant `DEV_ADDR`.
- `i2c_register`, out, 8: {reg[6:0], val[8]}.
- `i2c_data`, out, 8: val[7:0].
- `i2c_write`, out, 1: transfer request level to `i2c_write`.
- `i2c_done`, in, 1: completion level from `i2c_write`, synchronous to `sys_clk`.
- `busy`, out, 1: sequence in progress.
- `init_done`, out, 1: all 8 entries written.
- `error`, out, 1: timeout occurred; sequence aborted.
- `step`, out, 3: index of the current or last entry.

## Operation
- Table, index: reg=val:
  - 0: R15=0x000 (reset)
  - 1: R6=0x000 (power all on)
  - 2: R2=0x179 (HP 0 dB, both channels)
  - 3: R4=0x012 (DAC select, mic mute)
  - 4: R5=0x000 (DAC unmute)
  - 5: R7=0x00A (slave, 24-bit, I2S)
  - 6: R8=0x000 (normal, 48 kHz)
  - 7: R9=0x001 (active)
- States and transitions:
  - STARTUP: counter = STARTUP_CYCLES; goes to LOAD at 0.
  - LOAD: one cycle; latch table[step] onto `i2c_register` and `i2c_data`.
  - REQ: `i2c_write`=1, counter = TIMEOUT_CYCLES. Goes to REL on `i2c_done`=1. Goes to ERROR if the counter reaches 0 first.
  - REL: `i2c_write`=0; waits for `i2c_done`=0.
  - GAP: counter = GAP_CYCLES. At 0: if step==7 go to DONE, else step+1 and go to LOAD.
  - DONE: `init_done`=1.
  - ERROR: `error`=1, `i2c_write`=0; `step` holds the failing index.
- `busy`=1 in STARTUP, LOAD, REQ, REL and GAP.
- `start`: 2-flop synchroniser plus rising-edge detect.
  - In DONE or ERROR: clear `init_done` and `error`, step=0, go to LOAD (no startup delay).
  - In any other state: ignored.
- One shared 20-bit down-counter, loaded on state entry.

## Timing
- Reset values: `i2c_write` 0, `i2c_register` 0, `i2c_data` 0, `busy` 0, `init_done` 0, `error` 0, `step` 0. State is STARTUP.
- `i2c_addr` is constant at all times, including during reset.
- First cycle after reset deassertion: `busy`=1.
- All outputs are registered.
- `i2c_register` and `i2c_data` are stable at least 1 cycle before `i2c_write` rises, and stay unchanged until REL exits.
- `i2c_write` falls on the cycle after `i2c_done` is sampled high.
- The next `i2c_write` rise is no earlier than GAP_CYCLES+2 cycles after `i2c_done` falls.
- `i2c_done` high on the same cycle the timeout expires: done wins; the FSM goes to REL.
- `i2c_done` already high on entry to REQ (stale): treated as completion. The upstream master guarantees `done` is low when idle.
- `start` edge on the same cycle as entry to DONE: honoured on the next cycle.
- Reset mid-transfer: `i2c_write` drops asynchronously. `i2c_write` must share `rst`.
- Per-entry latency with zero-delay done: 1 (LOAD) + 1 (REQ) + 1 (REL) + GAP_CYCLES.

## Structure
- Package `codec_init_pkg` holds:
  - state enum;
  - WM8731 register-address constants;
  - `TABLE_LEN`=8;
  - 20-bit counter width.
- Sub-module `codec_init_rom`: combinational 3-bit index -> {7-bit reg, 9-bit val}. It performs the byte packing into `i2c_register`/`i2c_data`.
- Synchroniser, edge detect, counter and FSM are in `codec_init_seq`.

## Test plan
Bench parameters: STARTUP 10, GAP 4, TIMEOUT 100. The I2C model answers `done` 20 cycles after `write`, and drops it 1 cycle after `write` falls.
- Full run -> exactly 8 `i2c_write` pulses with (register,data) pairs 1E/00, 0C/00, 05/79, 08/12, 0A/00, 0E/0A, 10/00, 12/01, `i2c_addr`=34 throughout; then `init_done`=1, `busy`=0, `step`=7.
- Model never answers entry 3 -> `error`=1 exactly 100 cycles after that `write` rise; `write`=0, `step`=3, no further requests.
- `start` pulse in ERROR -> sequence restarts at entry 0 with no startup delay; `error` clears; completes normally.
- `start` pulsed during entry 2 -> ignored; table order and pulse count unchanged.
- `rst` low during REQ of entry 5 -> all outputs at reset values immediately; after release, full 8-entry run from entry 0 after 10 cycles.
- Model asserts `done` on the exact timeout cycle -> REL taken, `error` stays 0.

Source files
------------

// File: rtl/codec_init_pkg.sv
// Shared types and constants for the WM8731 power-up configuration sequencer.
// Register addresses follow the WM8731 register map (7-bit address field).
package codec_init_pkg;

    localparam int TABLE_LEN = 8;
    localparam int CNT_W     = 20;

    localparam logic [6:0] REG_LHP_OUT      = 7'h02;
    localparam logic [6:0] REG_ANALOG_PATH  = 7'h04;
    localparam logic [6:0] REG_DIGITAL_PATH = 7'h05;
    localparam logic [6:0] REG_POWER_DOWN   = 7'h06;
    localparam logic [6:0] REG_DIGITAL_IF   = 7'h07;
    localparam logic [6:0] REG_SAMPLING     = 7'h08;
    localparam logic [6:0] REG_ACTIVE       = 7'h09;
    localparam logic [6:0] REG_RESET        = 7'h0F;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_LOAD,
        ST_REQ,
        ST_REL,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic is_busy(input state_t s);
        case (s)
            ST_STARTUP, ST_LOAD, ST_REQ, ST_REL, ST_GAP: is_busy = 1'b1;
            default:                                     is_busy = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Fixed WM8731 init table; packs each {reg, 9-bit value} entry into the two
// I2C payload bytes {reg[6:0], val[8]} and val[7:0].
module codec_init_rom
    import codec_init_pkg::*;
(
    input  logic [2:0] i_index,
    output logic [7:0] o_register,
    output logic [7:0] o_data
);

    logic [6:0] w_reg;
    logic [8:0] w_val;

    always_comb begin
        w_reg = REG_RESET;
        w_val = 9'h000;
        case (i_index)
            3'd0: begin w_reg = REG_RESET;        w_val = 9'h000; end
            3'd1: begin w_reg = REG_POWER_DOWN;   w_val = 9'h000; end
            3'd2: begin w_reg = REG_LHP_OUT;      w_val = 9'h179; end
            3'd3: begin w_reg = REG_ANALOG_PATH;  w_val = 9'h012; end
            3'd4: begin w_reg = REG_DIGITAL_PATH; w_val = 9'h000; end
            3'd5: begin w_reg = REG_DIGITAL_IF;   w_val = 9'h00A; end
            3'd6: begin w_reg = REG_SAMPLING;     w_val = 9'h000; end
            3'd7: begin w_reg = REG_ACTIVE;       w_val = 9'h001; end
            default: begin w_reg = REG_RESET;     w_val = 9'h000; end
        endcase
    end

    assign o_register = {w_reg, w_val[8]};
    assign o_data     = w_val[7:0];

endmodule

// File: rtl/codec_init_seq.sv
// WM8731 power-up sequencer: walks the init table and hands each entry to the
// i2c_write master through its write/done level handshake.
module codec_init_seq
    import codec_init_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR       = 8'h34,
    parameter int unsigned STARTUP_CYCLES = 50_000,
    parameter int unsigned GAP_CYCLES     = 500,
    parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic [7:0] o_i2c_addr,
    output logic [7:0] o_i2c_register,
    output logic [7:0] o_i2c_data,
    output logic       o_i2c_write,
    input  logic       i_i2c_done,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_error,
    output logic [2:0] o_step
);

    localparam logic [CNT_W-1:0] STARTUP_LOAD = CNT_W'(STARTUP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [2:0]       r_step;
    logic [2:0]       w_step_nxt;
    logic             r_start_meta;
    logic             r_start_sync;
    logic             r_start_prev;
    logic             r_start_pend;
    logic             r_write;
    logic             r_busy;
    logic             r_init_done;
    logic             r_error;
    logic [7:0]       r_register;
    logic [7:0]       r_data;
    logic             w_start_edge;
    logic             w_start_go;
    logic             w_count_last;
    logic [7:0]       w_rom_register;
    logic [7:0]       w_rom_data;

    codec_init_rom u_rom (
        .i_index    (w_step_nxt),
        .o_register (w_rom_register),
        .o_data     (w_rom_data)
    );

    // An edge arriving as the sequence lands in DONE is held for one cycle so it is not lost.
    assign w_start_edge = r_start_sync & ~r_start_prev;
    assign w_start_go   = w_start_edge | r_start_pend;
    assign w_count_last = (r_count == CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            ST_STARTUP: if (w_count_last) w_state_nxt = ST_LOAD;
            ST_LOAD:    w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (i_i2c_done)        w_state_nxt = ST_REL;
                else if (w_count_last) w_state_nxt = ST_ERROR;
            end
            ST_REL:     if (!i_i2c_done) w_state_nxt = ST_GAP;
            ST_GAP: begin
                if (w_count_last) begin
                    if (r_step == 3'(TABLE_LEN - 1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_step_nxt  = r_step + 3'd1;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (w_start_go) begin
                    w_step_nxt  = 3'd0;
                    w_state_nxt = ST_LOAD;
                end
            end
            default:    w_state_nxt = ST_STARTUP;
        endcase
    end

    // The shared down-counter reloads on every state change; each timed state lasts exactly its load value.
    always_comb begin
        w_count_nxt = r_count;
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                ST_STARTUP: w_count_nxt = STARTUP_LOAD;
                ST_REQ:     w_count_nxt = TIMEOUT_LOAD;
                ST_GAP:     w_count_nxt = GAP_LOAD;
                default:    w_count_nxt = '0;
            endcase
        end else if (r_count != '0) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_STARTUP;
            r_count      <= STARTUP_LOAD;
            r_step       <= 3'd0;
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_start_prev <= 1'b0;
            r_start_pend <= 1'b0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
            r_init_done  <= 1'b0;
            r_error      <= 1'b0;
            r_register   <= 8'h00;
            r_data       <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_step       <= w_step_nxt;
            r_start_meta <= i_start;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_start_pend <= w_start_edge && (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
            r_write      <= (w_state_nxt == ST_REQ);
            r_busy       <= is_busy(w_state_nxt);
            r_init_done  <= (w_state_nxt == ST_DONE);
            r_error      <= (w_state_nxt == ST_ERROR);
            // Payload is latched on entry to LOAD so it settles a full cycle before the write request.
            if (w_state_nxt == ST_LOAD) begin
                r_register <= w_rom_register;
                r_data     <= w_rom_data;
            end
        end
    end

    assign o_i2c_addr     = DEV_ADDR;
    assign o_i2c_register = r_register;
    assign o_i2c_data     = r_data;
    assign o_i2c_write    = r_write;
    assign o_busy         = r_busy;
    assign o_init_done    = r_init_done;
    assign o_error        = r_error;
    assign o_step         = r_step;

endmodule
